vec_io_bridge: RTL

- Model-side responder for the host chunk protocol (wr_in / in_data / in_data_ready / rd_out / out_data / ml_inf_valid).
- Deserialises INVECWIDTH signed chunks into a flat vector and launches the compute core with a one-cycle start pulse.
- Captures the core result vector and serialises it back out chunk by chunk on host reads.
- Sits between the host/testbench and the generated MVProd -> Bias -> ReLU pipeline.

---
 rtl/vec_io_bridge.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vec_io_bridge.sv
// Host-side chunk deserialiser/serialiser that launches the compute core and returns its result.
// Optional sticky error flags are enabled with `define VEC_IO_ERR_EN.
`timescale 1ns/1ps
module vec_io_bridge #(
    parameter int INVECWIDTH  = 8,
    parameter int OUTVECWIDTH = 8,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8
) (
    input  logic                          clk_100mhz,
    input  logic                          sys_rst,
    input  logic                          wr_in,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_data_ready,
    input  logic                          rd_out,
    output logic [OUT_W-1:0]              out_data,
    output logic                          ml_inf_valid,
    output logic [INVECWIDTH*IN_W-1:0]    core_in_vec,
    output logic                          core_start,
    input  logic                          core_done,
    input  logic [OUTVECWIDTH*OUT_W-1:0]  core_out_vec,
    output logic                          busy
`ifdef VEC_IO_ERR_EN
    ,
    output logic [1:0]                    err_flags
`endif
);

    localparam int WP_W = $clog2(INVECWIDTH + 1);
    localparam int RP_W = (OUTVECWIDTH > 1) ? $clog2(OUTVECWIDTH) : 1;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_WAIT, S_READY} state_t;

    state_t                       state, next_state;
    logic [WP_W-1:0]              wptr, wcount;
    logic [RP_W-1:0]              rptr;
    logic                         wr_in_q;
    logic [IN_W-1:0]              in_buf     [INVECWIDTH];
    logic [IN_W-1:0]              in_buf_upd [INVECWIDTH];
    logic [OUT_W-1:0]             out_buf    [OUTVECWIDTH];
    logic [INVECWIDTH*IN_W-1:0]   in_vec_upd;
    logic                         write_ok, commit, wr_rise, done_take;

    // The commit snapshot must include a write landing in the same cycle as the strobe.
    always_comb begin
        write_ok  = (state == S_LOAD) && wr_in && (wptr < WP_W'(INVECWIDTH));
        wcount    = wptr + WP_W'(write_ok);
        commit    = (state == S_LOAD) && in_data_ready && (wcount == WP_W'(INVECWIDTH));
        wr_rise   = (state == S_READY) && wr_in && !wr_in_q;
        done_take = ((state == S_RUN) || (state == S_WAIT)) && core_done;
        for (int unsigned i = 0; i < INVECWIDTH; i++) begin
            in_buf_upd[i] = in_buf[i];
            if (write_ok && (wptr == WP_W'(i)))
                in_buf_upd[i] = in_data;
            in_vec_upd[i*IN_W +: IN_W] = in_buf_upd[i];
        end
    end

    always_comb begin
        next_state = state;
        core_start = (state == S_RUN);
        busy       = (state == S_RUN) || (state == S_WAIT);
        case (state)
            S_LOAD:  if (commit)    next_state = S_RUN;
            S_RUN:   next_state = core_done ? S_READY : S_WAIT;
            S_WAIT:  if (core_done) next_state = S_READY;
            S_READY: if (wr_rise)   next_state = S_LOAD;
            default: next_state = S_LOAD;
        endcase
    end

    always_comb begin
        out_data = '0;
        if ((state == S_READY) && rd_out) begin
            for (int unsigned i = 0; i < OUTVECWIDTH; i++)
                if (rptr == RP_W'(i))
                    out_data = out_buf[i];
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst)
            state <= S_LOAD;
        else
            state <= next_state;
    end

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            wptr         <= '0;
            rptr         <= '0;
            wr_in_q      <= 1'b0;
            ml_inf_valid <= 1'b0;
            core_in_vec  <= '0;
            for (int unsigned i = 0; i < INVECWIDTH; i++)
                in_buf[i] <= '0;
            for (int unsigned i = 0; i < OUTVECWIDTH; i++)
                out_buf[i] <= '0;
        end else begin
            wr_in_q <= wr_in;
            if (state == S_LOAD) begin
                in_buf <= in_buf_upd;
                if (commit) begin
                    wptr        <= '0;
                    core_in_vec <= in_vec_upd;
                end else begin
                    wptr <= wcount;
                end
            end
            if (done_take) begin
                for (int unsigned i = 0; i < OUTVECWIDTH; i++)
                    out_buf[i] <= core_out_vec[i*OUT_W +: OUT_W];
                ml_inf_valid <= 1'b1;
                rptr         <= '0;
            end
            if (state == S_READY) begin
                if (rd_out)
                    rptr <= (rptr == RP_W'(OUTVECWIDTH - 1)) ? '0 : rptr + RP_W'(1);
                // Restart only on a fresh wr_in edge; this cycle's chunk becomes chunk 0.
                if (wr_rise) begin
                    ml_inf_valid <= 1'b0;
                    in_buf[0]    <= in_data;
                    wptr         <= WP_W'(1);
                end
            end
        end
    end

`ifdef VEC_IO_ERR_EN
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            err_flags <= '0;
        end else if (state == S_LOAD) begin
            if (wr_in && (wptr == WP_W'(INVECWIDTH)))
                err_flags[0] <= 1'b1;
            if (in_data_ready && (wcount != WP_W'(INVECWIDTH)))
                err_flags[1] <= 1'b1;
        end
    end
`endif

endmodule
